// File: rtl/mac_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_dot_seq
// Description : Serial dot-product sequencer around one time-shared MAC;
//               streams operand pairs in, presents the accumulated sum out.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_dot_seq #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       len,
    input  logic                       tc,
    output logic                       busy,
    input  logic [A_WIDTH-1:0]         a_in,
    input  logic [B_WIDTH-1:0]         b_in,
    input  logic                       op_valid,
    output logic                       op_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] result,
    output logic                       res_valid,
    input  logic                       res_ready
);

    localparam int c_WIDTH = A_WIDTH + B_WIDTH;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [LEN_WIDTH-1:0] c_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [c_WIDTH-1:0]   r_acc;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic                 r_tc;
    logic [c_WIDTH-1:0]   r_result;
    logic                 r_res_valid;

    logic [c_WIDTH-1:0]   w_a_ext;
    logic [c_WIDTH-1:0]   w_b_ext;
    logic [c_WIDTH-1:0]   w_sum;
    logic                 w_xfer;

    // Extension sign bit is gated by the latched signedness, so one multiplier
    // serves both modes; only the low c_WIDTH bits of product and sum are kept.
    assign w_a_ext = {{B_WIDTH{a_in[A_WIDTH-1] & r_tc}}, a_in};
    assign w_b_ext = {{A_WIDTH{b_in[B_WIDTH-1] & r_tc}}, b_in};
    assign w_sum   = (w_a_ext * w_b_ext) + r_acc;
    assign w_xfer  = op_valid && (r_state == c_ACCUM);

    assign op_ready  = (r_state == c_ACCUM);
    assign busy      = (r_state != c_IDLE);
    assign result    = r_result;
    assign res_valid = r_res_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_tc        <= 1'b0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_tc        <= tc;
                        r_remaining <= len;
                        r_acc       <= '0;
                        if (len == '0) begin
                            r_result    <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_state <= c_ACCUM;
                        end
                    end
                end
                c_ACCUM: begin
                    if (w_xfer) begin
                        r_acc       <= w_sum;
                        r_remaining <= r_remaining - c_ONE;
                        if (r_remaining == c_ONE) begin
                            r_result    <= w_sum;
                            r_res_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
